// File: rtl/ground_render.sv
// Ground band renderer: per-frame snapshot of the scroller bitmap, x2 horizontal scale, 2-cycle pipe.
// Optional GROUND_FLASH_EN: frozen ground blinks on frame_cnt[4] while the game is not running.
module ground_render #(
    parameter int GROUND_Y = 400,
    parameter int GROUND_H = 8,
    parameter int H_ACTIVE = 640
) (
    input  logic         CLK,
    input  logic         N_rst,
    input  logic [319:0] px,
    input  logic         game_status,
    input  logic         frame_start,
    input  logic [9:0]   h_cnt,
    input  logic [9:0]   v_cnt,
    input  logic         video_on,
    output logic         ground_pixel,
    output logic         pixel_valid,
    output logic [7:0]   frame_cnt
);

    localparam logic [9:0] Y_LO    = 10'(GROUND_Y);
    localparam logic [9:0] Y_HI    = 10'(GROUND_Y + GROUND_H);
    localparam logic [9:0] H_MAX   = 10'(H_ACTIVE);
    localparam logic [8:0] IDX_TOP = 9'd319;

    logic [319:0] frame_buf_q, frame_buf_d;
    logic         snap_done_q, snap_done_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;

    logic         in_band_q, in_band_d;
    logic [8:0]   idx_q, idx_d;
    logic         vld1_q;

    logic         gp_q, gp_d;
    logic         pv_q;
    logic         blank;

    // Snapshot: once frozen, only a reset re-arms capture while idle
    always_comb begin
        frame_buf_d = frame_buf_q;
        snap_done_d = snap_done_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (game_status || !snap_done_q) begin
                frame_buf_d = px;
                snap_done_d = 1'b1;
            end
        end
    end

    // Out-of-band coordinates park idx at 0 so the lookup stays in range
    always_comb begin
        in_band_d = video_on
                  && (v_cnt >= Y_LO)
                  && (v_cnt < Y_HI)
                  && (h_cnt < H_MAX);
        idx_d = 9'd0;
        if (in_band_d) begin
            idx_d = IDX_TOP - h_cnt[9:1];
        end
    end

`ifdef GROUND_FLASH_EN
    assign blank = !game_status && snap_done_q && !frame_cnt_q[4];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        gp_d = in_band_q && frame_buf_q[idx_q] && !blank;
    end

    always_ff @(posedge CLK or negedge N_rst) begin
        if (!N_rst) begin
            frame_buf_q <= '0;
            snap_done_q <= 1'b0;
            frame_cnt_q <= 8'd0;
            in_band_q   <= 1'b0;
            idx_q       <= 9'd0;
            vld1_q      <= 1'b0;
            gp_q        <= 1'b0;
            pv_q        <= 1'b0;
        end else begin
            frame_buf_q <= frame_buf_d;
            snap_done_q <= snap_done_d;
            frame_cnt_q <= frame_cnt_d;
            in_band_q   <= in_band_d;
            idx_q       <= idx_d;
            vld1_q      <= video_on;
            gp_q        <= gp_d;
            pv_q        <= vld1_q;
        end
    end

    assign ground_pixel = gp_q;
    assign pixel_valid  = pv_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_ground_render.sv
// Self-checking bench for ground_render: vector table, directed sequences, random vs reference model.
// Build with +define+GROUND_FLASH_EN to exercise the blink variant.
module tb_ground_render;

    logic         CLK;
    logic         N_rst;
    logic [319:0] px;
    logic         game_status;
    logic         frame_start;
    logic [9:0]   h_cnt;
    logic [9:0]   v_cnt;
    logic         video_on;
    logic         ground_pixel;
    logic         pixel_valid;
    logic [7:0]   frame_cnt;

    ground_render dut (
        .CLK          (CLK),
        .N_rst        (N_rst),
        .px           (px),
        .game_status  (game_status),
        .frame_start  (frame_start),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .video_on     (video_on),
        .ground_pixel (ground_pixel),
        .pixel_valid  (pixel_valid),
        .frame_cnt    (frame_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic gp;
        logic pv;
        bit   chk;
    } exp_t;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       vo;
        logic       gp;
        logic       pv;
    } vec_t;

    int passed = 0;
    int total  = 0;

    exp_t         q[$];
    logic [319:0] mbuf;
    bit           msnap;
    int           mcnt;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    // Reference: beam column c shows bitmap bit 319 - floor(c/2)
    function automatic logic model_gp(input int h, input int v, input logic vo);
        logic r;
        r = 1'b0;
        if (vo && v >= 400 && v < 408 && h < 640) r = mbuf[319 - h / 2];
`ifdef GROUND_FLASH_EN
        if (!game_status && msnap && ((mcnt / 16) % 2 == 0)) r = 1'b0;
`endif
        return r;
    endfunction

    task automatic model_reset();
        mbuf  = '0;
        msnap = 0;
        mcnt  = 0;
        q.delete();
    endtask

    // One pixel clock; called at a falling edge, returns at the next one
    task automatic cyc(input int h, input int v, input logic vo, input logic fs);
        exp_t e;
        h_cnt       = 10'(h);
        v_cnt       = 10'(v);
        video_on    = vo;
        frame_start = fs;
        e.pv  = vo;
        e.gp  = model_gp(h, v, vo);
        e.chk = !fs;
        q.push_back(e);
        @(posedge CLK);
        if (fs) begin
            mcnt = (mcnt + 1) % 256;
            if (game_status || !msnap) begin
                mbuf  = px;
                msnap = 1;
            end
        end
        @(negedge CLK);
        frame_start = 1'b0;
        check("frame_cnt", int'(frame_cnt), mcnt);
        if (q.size() >= 2) begin
            e = q.pop_front();
            if (e.chk) check("ground_pixel", int'(ground_pixel), int'(e.gp));
            check("pixel_valid", int'(pixel_valid), int'(e.pv));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1'b0, 1'b0);
    endtask

    task automatic snap();
        idle(2);
        cyc(0, 0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic set_status(input logic g);
        idle(2);
        game_status = g;
        idle(2);
    endtask

    task automatic sweep_row(input int v, input bit lo16);
        for (int h = 0; h < 640; h++) begin
            cyc(h, v, 1'b1, 1'b0);
            if (lo16 && h >= 1) check("sweep_lo16", int'(ground_pixel), int'(h - 1 < 16));
        end
        idle(2);
    endtask

    task automatic do_reset();
        N_rst = 1'b0;
        #1;
        check("rst_gp", int'(ground_pixel), 0);
        check("rst_pv", int'(pixel_valid), 0);
        check("rst_cnt", int'(frame_cnt), 0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        N_rst = 1'b1;
    endtask

    vec_t vt[10];
    logic [319:0] ones;
    logic [319:0] pat;
    logic [319:0] old_buf;
    int           c0;

    initial begin
        ones        = '1;
        pat         = {8'hFF, 312'h0};
        N_rst       = 1'b0;
        px          = '0;
        game_status = 1'b1;
        frame_start = 1'b0;
        h_cnt       = '0;
        v_cnt       = '0;
        video_on    = 1'b0;
        model_reset();
        #12;
        check("reset_gp", int'(ground_pixel), 0);
        check("reset_pv", int'(pixel_valid), 0);
        check("reset_cnt", int'(frame_cnt), 0);
        @(negedge CLK);
        N_rst = 1'b1;

        // Left 8 bitmap bits -> columns 0..15
        px = pat;
        snap();
        sweep_row(400, 1);
        sweep_row(407, 1);
        sweep_row(399, 0);
        sweep_row(408, 0);

        // Live bitmap changes are ignored until the next frame_start
        px = ones;
        sweep_row(400, 1);
        snap();
        sweep_row(403, 0);

        vt[0] = '{10'd0,    10'd400, 1'b1, 1'b1, 1'b1};
        vt[1] = '{10'd639,  10'd407, 1'b1, 1'b1, 1'b1};
        vt[2] = '{10'd640,  10'd402, 1'b1, 1'b0, 1'b1};
        vt[3] = '{10'd700,  10'd402, 1'b1, 1'b0, 1'b1};
        vt[4] = '{10'd1023, 10'd402, 1'b1, 1'b0, 1'b1};
        vt[5] = '{10'd10,   10'd402, 1'b0, 1'b0, 1'b0};
        vt[6] = '{10'd10,   10'd399, 1'b1, 1'b0, 1'b1};
        vt[7] = '{10'd10,   10'd408, 1'b1, 1'b0, 1'b1};
        vt[8] = '{10'd320,  10'd404, 1'b1, 1'b1, 1'b1};
        vt[9] = '{10'd1,    10'd405, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            cyc(int'(vt[i].h), int'(vt[i].v), vt[i].vo, 1'b0);
            cyc(0, 0, 1'b0, 1'b0);
            check($sformatf("vec%0d_gp", i), int'(ground_pixel), int'(vt[i].gp));
            check($sformatf("vec%0d_pv", i), int'(pixel_valid), int'(vt[i].pv));
        end

        // Counter wraps after 256 pulses
        c0 = int'(frame_cnt);
        for (int i = 0; i < 256; i++) cyc(0, 0, 1'b0, 1'b1);
        idle(1);
        check("cnt_wrap", int'(frame_cnt), c0);

        // Frozen on game over; blink variant tracks frame_cnt[4]
        set_status(1'b0);
        px = pat;
        snap();
        check("frozen_buf", int'(mbuf == ones), 1);
        for (int f = 0; f < 40; f++) begin
            cyc(0, 0, 1'b0, 1'b1);
            cyc(100, 401, 1'b1, 1'b0);
            cyc(0, 0, 1'b0, 1'b0);
`ifdef GROUND_FLASH_EN
            check("flash", int'(ground_pixel), int'(frame_cnt[4]));
`else
            check("steady", int'(ground_pixel), 1);
`endif
        end

        // Reset in the middle of the band, then idle re-capture
        for (int h = 200; h < 210; h++) cyc(h, 404, 1'b1, 1'b0);
        do_reset();
        game_status = 1'b0;
        px = pat;
        snap();
        sweep_row(406, 1);
        old_buf = mbuf;
        px = ones;
        snap();
        check("idle_hold", int'(mbuf == old_buf), 1);

        // Frame start during active video is legal
        game_status = 1'b1;
        idle(2);
        for (int h = 0; h < 40; h++) cyc(h, 402, 1'b1, logic'(h == 20));
        idle(2);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) set_status(logic'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) px = {$urandom, $urandom, $urandom, $urandom,
                                                 $urandom, $urandom, $urandom, $urandom,
                                                 $urandom, $urandom};
            cyc(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                            : int'($urandom_range(0, 639)),
                int'($urandom_range(396, 411)),
                logic'($urandom_range(0, 7) != 0),
                logic'($urandom_range(0, 29) == 0));
        end
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
